// File: rtl/vertex_stream_sequencer.sv
// Vertex stream sequencer: reads vertices from a buffer and issues them to the projection pipe under
// a credit limit, then reorders nothing and streams indexed results out through a small FIFO.
//
// state   | meaning
// IDLE    | waiting for start; vertex_count = 0 completes a pass here
// ISSUE   | issuing buffer reads 0..count-1, one per cycle while credit allows
// DRAIN   | all reads issued; waiting for the last result to leave the FIFO
module vertex_stream_sequencer #(
  parameter  int MAX_VERTS = 64,
  parameter  int OUT_DEPTH = 8,
  localparam int ADDR_W    = $clog2(MAX_VERTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   vertex_count,
  input  logic              loop_mode,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [47:0]       mem_rd_data,
  output logic              pipe_vertex_valid,
  output logic [47:0]       pipe_vertex,
  input  logic              pipe_result_valid,
  input  logic [38:0]       pipe_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [38:0]       out_pt,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_count,
  output logic              err
);

  localparam int NW = ADDR_W + 1;
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 39 + ADDR_W;
  localparam logic [NW-1:0] MAX_N = NW'(MAX_VERTS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [NW-1:0]   cnt_q, rd_q, ret_q;
  logic [CW-1:0]   in_flight_q, fifo_count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]   fifo_mem [OUT_DEPTH];
  logic            done_q, err_q, pv_valid_q;
  logic [15:0]     pass_count_q;

  logic [NW-1:0]   cnt_in;
  logic            start_ok, credit_ok, rd_en, last_rd;
  logic            fifo_empty, fifo_full, pop, res_ok, push, drop;
  logic            last_pop, pass_end;
  logic [DW-1:0]   head;

  assign cnt_in     = (vertex_count > MAX_N) ? MAX_N : vertex_count;
  assign start_ok   = (state == S_IDLE) && start;
  assign credit_ok  = ({1'b0, in_flight_q} + {1'b0, fifo_count_q}) < (CW + 1)'(OUT_DEPTH);
  assign rd_en      = (state == S_ISSUE) && (rd_q < cnt_q) && credit_ok;
  assign last_rd    = rd_en && (rd_q == cnt_q - 1'b1);
  assign fifo_empty = (fifo_count_q == '0);
  assign fifo_full  = (fifo_count_q == CW'(OUT_DEPTH));
  assign pop        = !fifo_empty && out_ready;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign res_ok     = pipe_result_valid && (in_flight_q != '0);
  assign push       = res_ok && (!fifo_full || pop);
  assign drop       = pipe_result_valid && !push;
  assign head       = fifo_mem[rd_ptr_q];
  assign last_pop   = pop && (state == S_DRAIN) && ({1'b0, head[ADDR_W-1:0]} == cnt_q - 1'b1);
  assign pass_end   = last_pop || (start_ok && (cnt_in == '0));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok && (cnt_in != '0)) state_nxt = S_ISSUE;
      S_ISSUE: if (last_rd) state_nxt = S_DRAIN;
      S_DRAIN: if (last_pop) state_nxt = loop_mode ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rd_q  <= '0;
      ret_q <= '0;
    end else begin
      if (start_ok) cnt_q <= cnt_in;
      if (start_ok || (last_pop && loop_mode)) rd_q <= '0;
      else if (rd_en)                          rd_q <= rd_q + 1'b1;
      if (start_ok || last_pop) ret_q <= '0;
      else if (res_ok)          ret_q <= ret_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q <= '0;
    end else begin
      case ({rd_en, res_ok})
        2'b10:   in_flight_q <= in_flight_q + 1'b1;
        2'b01:   in_flight_q <= in_flight_q - 1'b1;
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {pipe_result, ret_q[ADDR_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pv_valid_q   <= 1'b0;
      pass_count_q <= '0;
    end else begin
      done_q     <= pass_end;
      pv_valid_q <= rd_en;
      if (drop) err_q <= 1'b1;
      if (start_ok)      pass_count_q <= (cnt_in == '0) ? 16'd1 : 16'd0;
      else if (last_pop) pass_count_q <= pass_count_q + 16'd1;
    end
  end

  assign mem_rd_en         = rd_en;
  assign mem_addr          = rd_q[ADDR_W-1:0];
  assign pipe_vertex_valid = pv_valid_q;
  assign pipe_vertex       = pv_valid_q ? mem_rd_data : '0;
  assign out_valid         = !fifo_empty;
  assign out_pt            = fifo_empty ? '0 : head[DW-1:ADDR_W];
  assign out_index         = fifo_empty ? '0 : head[ADDR_W-1:0];
  assign busy              = (state != S_IDLE);
  assign done              = done_q;
  assign pass_count        = pass_count_q;
  assign err               = err_q;

endmodule

// File: tb/tb_vertex_stream_sequencer.sv
// Directed bench for vertex_stream_sequencer: buffer model, 4-cycle pipe model, output monitor.
module tb_vertex_stream_sequencer;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   vertex_count;
  logic              loop_mode;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [47:0]       mem_rd_data;
  logic              pipe_vertex_valid;
  logic [47:0]       pipe_vertex;
  logic              pipe_result_valid;
  logic [38:0]       pipe_result;
  logic              out_valid;
  logic              out_ready;
  logic [38:0]       out_pt;
  logic [ADDR_W-1:0] out_index;
  logic              busy, done, err;
  logic [15:0]       pass_count;

  logic              inj_valid;
  logic [38:0]       inj_data;

  vertex_stream_sequencer #(.MAX_VERTS(64), .OUT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vertex_count(vertex_count), .loop_mode(loop_mode),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pipe_vertex_valid(pipe_vertex_valid), .pipe_vertex(pipe_vertex),
    .pipe_result_valid(pipe_result_valid), .pipe_result(pipe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_pt(out_pt), .out_index(out_index),
    .busy(busy), .done(done), .pass_count(pass_count), .err(err)
  );

  always #5 clk = ~clk;

  // Vertex buffer: entry 0 is (x,y,z) = (20.0, 23.0, -2.0) in f16.
  logic [47:0] vmem [64];
  initial begin
    for (int i = 0; i < 64; i++)
      vmem[i] = {16'(16'h3C00 + i * 3), 16'(16'hC100 + i * 7), 16'(16'h4000 ^ (i * 11))};
    vmem[0] = {16'hC000, 16'h4DC0, 16'h4D00};
  end

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= vmem[mem_addr];

  // Projection/raster stand-in: keeps the low 13 bits of each component, 4 cycles of latency.
  logic [3:0]  pv_sr;
  logic [38:0] pd_sr [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_sr <= '0;
      for (int k = 0; k < 4; k++) pd_sr[k] <= '0;
    end else begin
      pv_sr    <= {pv_sr[2:0], pipe_vertex_valid};
      pd_sr[0] <= {pipe_vertex[44:32], pipe_vertex[28:16], pipe_vertex[12:0]};
      for (int k = 1; k < 4; k++) pd_sr[k] <= pd_sr[k-1];
    end
  end
  assign pipe_result_valid = pv_sr[3] | inj_valid;
  assign pipe_result       = inj_valid ? inj_data : pd_sr[3];

  function automatic logic [38:0] exp_pt(input int i);
    logic [47:0] w;
    w = vmem[i];
    return {w[44:32], w[28:16], w[12:0]};
  endfunction

  logic [ADDR_W-1:0] pop_idx [$];
  logic [38:0]       pop_pt  [$];
  int done_cnt, rd_cnt;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        pop_idx.push_back(out_index);
        pop_pt.push_back(out_pt);
      end
      if (done) done_cnt++;
      if (mem_rd_en) rd_cnt++;
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    pop_idx.delete();
    pop_pt.delete();
    done_cnt = 0;
    rd_cnt   = 0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic check_pops(input string tag, input int n, input int period);
    chk({tag, "_pop_count"}, pop_idx.size(), n);
    for (int i = 0; i < n && i < pop_idx.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), pop_idx[i], i % period);
      chk($sformatf("%s_pt%0d", tag, i), pop_pt[i], exp_pt(i % period));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, n;
    rst_n = 1'b0; start = 1'b0; vertex_count = '0; loop_mode = 1'b0;
    out_ready = 1'b0; inj_valid = 1'b0; inj_data = '0;
    clr();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pass_count", pass_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // three vertices, always ready
    clr();
    vertex_count = 7'd3; loop_mode = 1'b0; out_ready = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("a_busy_after_start", busy, 1);
    wait_idle(100, "a");
    tick(2);
    check_pops("a", 3, 64);
    if (pop_pt.size() > 0) chk("a_pt0_literal", pop_pt[0], {13'h0000, 13'h0DC0, 13'h0D00});
    chk("a_done_pulses", done_cnt, 1);
    chk("a_pass_count", pass_count, 1);
    chk("a_err", err, 0);

    // credit limit with a stalled output
    clr();
    vertex_count = 7'd20; out_ready = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(30);
    chk("b_reads_stalled", rd_cnt, 8);
    chk("b_rd_en_low", mem_rd_en, 0);
    chk("b_out_valid", out_valid, 1);
    chk("b_busy", busy, 1);
    out_ready = 1'b1;
    wait_idle(200, "b");
    tick(2);
    chk("b_reads_total", rd_cnt, 20);
    check_pops("b", 20, 64);
    chk("b_err", err, 0);
    chk("b_pass_count", pass_count, 1);

    // count above depth clamps to 64
    clr();
    vertex_count = 7'd100; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(400, "c");
    tick(2);
    chk("c_reads_clamped", rd_cnt, 64);
    check_pops("c", 64, 64);
    chk("c_done_pulses", done_cnt, 1);

    // zero-length pass
    clr();
    vertex_count = 7'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("z_done_next_cycle", done, 1);
    chk("z_pass_count", pass_count, 1);
    chk("z_busy", busy, 0);
    tick(1);
    chk("z_done_one_cycle", done, 0);
    tick(3);
    chk("z_no_reads", rd_cnt, 0);

    // looping, loop_mode cleared during the third pass
    clr();
    vertex_count = 7'd4; loop_mode = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    nd = 0; n = 0;
    while (nd < 2 && n < 200) begin
      tick(1);
      n++;
      if (done) nd++;
    end
    chk("l_two_passes", nd, 2);
    chk("l_still_busy", busy, 1);
    loop_mode = 1'b0;
    wait_idle(200, "l");
    tick(2);
    chk("l_pass_count", pass_count, 3);
    chk("l_done_pulses", done_cnt, 3);
    check_pops("l", 12, 4);

    // stray result while idle, then reset mid-pass
    clr();
    inj_data = 39'h12345; inj_valid = 1'b1;
    tick(1);
    inj_valid = 1'b0;
    chk("e_err_set", err, 1);
    chk("e_fifo_untouched", out_valid, 0);
    vertex_count = 7'd20; out_ready = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    chk("e_pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("e_rst_busy", busy, 0);
    chk("e_rst_done", done, 0);
    chk("e_rst_err", err, 0);
    chk("e_rst_mem_rd_en", mem_rd_en, 0);
    chk("e_rst_pv_valid", pipe_vertex_valid, 0);
    chk("e_rst_pipe_vertex", pipe_vertex, 0);
    chk("e_rst_out_valid", out_valid, 0);
    chk("e_rst_out_pt", out_pt, 0);
    chk("e_rst_out_index", out_index, 0);
    chk("e_rst_pass_count", pass_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("e_post_err", err, 0);
    chk("e_post_out_valid", out_valid, 0);
    chk("e_post_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vertex_stream_sequencer.md
VERTEX_STREAM_SEQUENCER -- requirements
Module: vertex_stream_sequencer

Interface
REQ-001 Parameter MAX_VERTS, default 64: vertex buffer depth; ADDR_W = $clog2(MAX_VERTS).
REQ-002 Parameter OUT_DEPTH, default 8, power of two >= 2: output FIFO depth and in-flight credit limit.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  pulse; begins a pass when IDLE, ignored otherwise.
REQ-006 vertex_count  in  ADDR_W+1  vertices per pass; sampled on accepted start.
REQ-007 loop_mode  in  1  1 = repeat passes; sampled at each pass end.
REQ-008 mem_rd_en / mem_addr  out  1 / ADDR_W  vertex buffer read request and address.
REQ-009 mem_rd_data  in  48 (vec3_f16)  read data, valid exactly 1 cycle after mem_rd_en.
REQ-010 pipe_vertex_valid / pipe_vertex  out  1 / 48 (vec3_f16)  to the projection stage; no backpressure.
REQ-011 pipe_result_valid / pipe_result  in  1 / 39 (vec3_i13)  from the rasterize stage; results arrive in issue order, any latency.
REQ-012 out_valid / out_ready / out_pt / out_index  out / in / out / out  1 / 1 / 39 / ADDR_W  output stream with valid/ready handshake.
REQ-013 busy  out  1  high from accepted start until the final pass completes.
REQ-014 done  out  1  one-cycle pulse at the end of every pass.
REQ-015 pass_count  out  16  completed passes since start; wraps modulo 2^16.
REQ-016 err  out  1  sticky protocol error flag.

Function
REQ-017 States: IDLE, ISSUE, DRAIN. IDLE->ISSUE on start. ISSUE->DRAIN when the last read is issued. DRAIN->ISSUE (address 0) when the last result pops and loop_mode=1. DRAIN->IDLE when the last result pops and loop_mode=0.
REQ-018 vertex_count > MAX_VERTS is clamped to MAX_VERTS. vertex_count = 0: no reads; done pulses the cycle after start; go to IDLE.
REQ-019 Credit rule: mem_rd_en may assert only when in_flight + fifo_count < OUT_DEPTH. in_flight increments on mem_rd_en and decrements on pipe_result_valid.
REQ-020 With credit available, issue one read per cycle at addresses 0,1,... in order.
REQ-021 pipe_vertex_valid is registered mem_rd_en, delayed 1 cycle; pipe_vertex = mem_rd_data in that cycle.
REQ-022 On each pipe_result_valid, push {pipe_result, return index} into the FIFO. The return index counts 0..count-1 per pass.
REQ-023 out_valid = FIFO non-empty; out_pt/out_index come from the FIFO head. A pop occurs on out_valid & out_ready.
REQ-024 A push and a pop in the same cycle to a full FIFO are both legal; occupancy is unchanged.
REQ-025 done and the pass_count increment occur in the cycle after the pop of index count-1.
REQ-026 pipe_result_valid while in_flight = 0, or a push to a full FIFO without a simultaneous pop, drops the result and sets err. err clears only on reset.
REQ-027 start while busy is ignored.
REQ-028 Arithmetic on data: none; vertex and result words pass through bit-exact.

Reset
REQ-029 On rst_n low, immediately: state=IDLE, FIFO empty, all counters zero. busy, done, err, mem_rd_en, pipe_vertex_valid and out_valid are all 0. out_pt, out_index and pipe_vertex are 0.
REQ-030 Reset mid-pass discards all in-flight and buffered results. Results arriving after reset release while IDLE set err.

Verification
REQ-031 vertex_count=3, buffer {20,23,-2}… words, 4-cycle model pipe, out_ready=1 -> out_index 0,1,2 in order with bit-exact data, one done pulse, pass_count=1, busy falls.
REQ-032 vertex_count=20, OUT_DEPTH=8, out_ready=0 -> exactly 8 reads are issued, then mem_rd_en stays 0. Raising out_ready lets all 20 complete; err stays 0.
REQ-033 vertex_count=0 -> done pulses 1 cycle after start, mem_rd_en is never asserted, pass_count=1.
REQ-034 loop_mode=1, count=4 -> consecutive passes each emit indices 0-3 with a done pulse. Clearing loop_mode during pass 3 -> IDLE after pass 3, pass_count=3.
REQ-035 Inject pipe_result_valid while IDLE -> err=1, FIFO unchanged. rst_n pulsed low mid-pass -> all outputs at reset values and err=0.
